// File: rtl/compare_pkg.sv
// Shared definitions for the comparator result monitor.
// Provides the last_result encoding, the monitor FSM state type and the
// default outcome-counter width.
package compare_pkg;

  localparam int CNT_W_DEF = 8;

  localparam logic [1:0] RES_NONE    = 2'b00;
  localparam logic [1:0] RES_LESS    = 2'b01;
  localparam logic [1:0] RES_GREATER = 2'b10;
  localparam logic [1:0] RES_EQUAL   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_TRACK  = 2'b01,
    ST_LOCKED = 2'b10,
    ST_ERROR  = 2'b11
  } state_e;

  // Encode a legal (one-hot) flag set; callers guarantee exactly one flag is set.
  function automatic logic [1:0] flags_to_res(input logic less,
                                              input logic greater,
                                              input logic equal);
    logic [1:0] res;
    res = RES_NONE;
    if (equal)        res = RES_EQUAL;
    else if (greater) res = RES_GREATER;
    else if (less)    res = RES_LESS;
    return res;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over inc.
// Latency: count reflects an inc or clr one cycle after the edge.
// Backpressure: none; inc at the all-ones value is absorbed.
// Ports: clk, rst (async, active-high), clr, inc, count[W-1:0].
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/compare_result_monitor.sv
// Monitors one-hot less/greater/equal comparator flags: per-outcome saturating
// counts, last outcome, lock after STREAK_N consecutive equals, sticky error.
// Latency: 1 cycle from sampling edge to outputs. Backpressure: none; ERROR drops samples.
// Ports: clk, rst (async, active-high), clear, sample_valid, less, greater, equal
//        -> less_cnt, greater_cnt, equal_cnt, last_result[1:0], lock, error.
module compare_result_monitor
  import compare_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int STREAK_N = 3          // 1..15, fits the 4-bit streak register
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             sample_valid,
  input  logic             less,
  input  logic             greater,
  input  logic             equal,
  output logic [CNT_W-1:0] less_cnt,
  output logic [CNT_W-1:0] greater_cnt,
  output logic [CNT_W-1:0] equal_cnt,
  output logic [1:0]       last_result,
  output logic             lock,
  output logic             error
);

  localparam logic [3:0] STREAK_MAX = 4'(STREAK_N);

  state_e     state_q;
  logic [3:0] streak_q;
  logic [3:0] streak_d;
  logic [1:0] last_q;
  logic       lock_q;
  logic       error_q;

  logic legal;
  logic accept;

  // Exactly one flag high; 000 and every multi-hot code are illegal.
  assign legal = (less & ~greater & ~equal) |
                 (~less & greater & ~equal) |
                 (~less & ~greater & equal);

  // A sample only reaches the counters when it is legal, not swallowed by the
  // sticky error state, and not overridden by a same-cycle clear.
  assign accept = sample_valid & legal & ~clear & (state_q != ST_ERROR);

  // Streak stops at STREAK_N so a long equal run in LOCKED cannot wrap.
  assign streak_d = (streak_q == STREAK_MAX) ? STREAK_MAX : streak_q + 4'd1;

  sat_counter #(.W(CNT_W)) u_less_cnt (
    .clk(clk), .rst(rst), .clr(clear), .inc(accept & less), .count(less_cnt)
  );

  sat_counter #(.W(CNT_W)) u_greater_cnt (
    .clk(clk), .rst(rst), .clr(clear), .inc(accept & greater), .count(greater_cnt)
  );

  sat_counter #(.W(CNT_W)) u_equal_cnt (
    .clk(clk), .rst(rst), .clr(clear), .inc(accept & equal), .count(equal_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      streak_q <= '0;
      last_q   <= RES_NONE;
      lock_q   <= 1'b0;
      error_q  <= 1'b0;
    end else if (clear) begin
      state_q  <= ST_IDLE;
      streak_q <= '0;
      last_q   <= RES_NONE;
      lock_q   <= 1'b0;
      error_q  <= 1'b0;
    end else if (sample_valid && (state_q != ST_ERROR)) begin
      if (!legal) begin
        state_q <= ST_ERROR;
        lock_q  <= 1'b0;
        error_q <= 1'b1;
      end else begin
        last_q <= flags_to_res(less, greater, equal);
        if (equal) begin
          // IDLE always holds streak 0, so IDLE and TRACK share this path.
          streak_q <= streak_d;
          if (streak_d == STREAK_MAX) begin
            state_q <= ST_LOCKED;
            lock_q  <= 1'b1;
          end else begin
            state_q <= ST_TRACK;
            lock_q  <= 1'b0;
          end
        end else begin
          streak_q <= '0;
          state_q  <= ST_TRACK;
          lock_q   <= 1'b0;
        end
      end
    end
  end

  assign last_result = last_q;
  assign lock        = lock_q;
  assign error       = error_q;

endmodule

// File: tb/tb_compare_result_monitor.sv
// Directed bench: two monitors (CNT_W=8 and CNT_W=2) share one stimulus
// stream and are compared every cycle against a run-length/count model,
// plus hand-computed literal checkpoints.
module tb_compare_result_monitor;

  localparam int STREAK_N = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear = 1'b0;
  logic sample_valid = 1'b0;
  logic less = 1'b0;
  logic greater = 1'b0;
  logic equal = 1'b0;

  logic [7:0] less_cnt, greater_cnt, equal_cnt;
  logic [1:0] last_result;
  logic       lock, error;

  logic [1:0] s_less_cnt, s_greater_cnt, s_equal_cnt;
  logic [1:0] s_last_result;
  logic       s_lock, s_error;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  compare_result_monitor #(.CNT_W(8), .STREAK_N(STREAK_N)) dut (
    .clk(clk), .rst(rst), .clear(clear), .sample_valid(sample_valid),
    .less(less), .greater(greater), .equal(equal),
    .less_cnt(less_cnt), .greater_cnt(greater_cnt), .equal_cnt(equal_cnt),
    .last_result(last_result), .lock(lock), .error(error)
  );

  compare_result_monitor #(.CNT_W(2), .STREAK_N(STREAK_N)) dut_s (
    .clk(clk), .rst(rst), .clear(clear), .sample_valid(sample_valid),
    .less(less), .greater(greater), .equal(equal),
    .less_cnt(s_less_cnt), .greater_cnt(s_greater_cnt), .equal_cnt(s_equal_cnt),
    .last_result(s_last_result), .lock(s_lock), .error(s_error)
  );

  // ---------------- model: unbounded tallies, run length, error flag -------
  int m_less = 0, m_greater = 0, m_equal = 0;
  int m_run = 0;        // consecutive accepted equals
  int m_last = 0;       // 0 none, 1 less, 2 greater, 3 equal
  bit m_err = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_less = 0; m_greater = 0; m_equal = 0; m_run = 0; m_last = 0; m_err = 1'b0;
    end else if (clear) begin
      m_less = 0; m_greater = 0; m_equal = 0; m_run = 0; m_last = 0; m_err = 1'b0;
    end else if (sample_valid && !m_err) begin
      if ((int'(less) + int'(greater) + int'(equal)) != 1) begin
        m_err = 1'b1;
      end else if (less) begin
        m_less++; m_last = 1; m_run = 0;
      end else if (greater) begin
        m_greater++; m_last = 2; m_run = 0;
      end else begin
        m_equal++; m_last = 3; m_run++;
      end
    end
  end

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    chk("cmp less_cnt",      32'(less_cnt),      sat(m_less, 8));
    chk("cmp greater_cnt",   32'(greater_cnt),   sat(m_greater, 8));
    chk("cmp equal_cnt",     32'(equal_cnt),     sat(m_equal, 8));
    chk("cmp last_result",   32'(last_result),   m_last);
    chk("cmp lock",          32'(lock),          int'(!m_err && m_run >= STREAK_N));
    chk("cmp error",         32'(error),         int'(m_err));
    chk("cmp s_less_cnt",    32'(s_less_cnt),    sat(m_less, 2));
    chk("cmp s_greater_cnt", 32'(s_greater_cnt), sat(m_greater, 2));
    chk("cmp s_equal_cnt",   32'(s_equal_cnt),   sat(m_equal, 2));
    chk("cmp s_lock",        32'(s_lock),        int'(!m_err && m_run >= STREAK_N));
    chk("cmp s_error",       32'(s_error),       int'(m_err));
  end

  // Drive one cycle of inputs at the falling edge; flags as {less,greater,equal}.
  task automatic drive(input logic c, input logic v, input logic [2:0] f);
    @(negedge clk);
    clear = c;
    sample_valid = v;
    less = f[2];
    greater = f[1];
    equal = f[0];
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 3'b000);
  endtask

  localparam logic [2:0] F_L = 3'b100;
  localparam logic [2:0] F_G = 3'b010;
  localparam logic [2:0] F_E = 3'b001;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset less_cnt", 32'(less_cnt), 0);
    chk("reset last", 32'(last_result), 0);
    chk("reset lock", 32'(lock), 0);
    chk("reset error", 32'(error), 0);

    // Mixed sequence
    drive(0, 1, F_L); drive(0, 1, F_G); drive(0, 1, F_G); drive(0, 1, F_E); idle();
    chk("mix less_cnt", 32'(less_cnt), 1);
    chk("mix greater_cnt", 32'(greater_cnt), 2);
    chk("mix equal_cnt", 32'(equal_cnt), 1);
    chk("mix last", 32'(last_result), 3);
    chk("mix lock", 32'(lock), 0);

    // Lock and release
    drive(1, 0, 3'b000);
    drive(0, 1, F_E); drive(0, 1, F_E); idle();
    chk("two eq lock", 32'(lock), 0);
    drive(0, 1, F_E); idle();
    chk("three eq lock", 32'(lock), 1);
    chk("three eq equal_cnt", 32'(equal_cnt), 3);
    drive(0, 1, F_E); idle();
    chk("four eq lock", 32'(lock), 1);
    chk("four eq equal_cnt", 32'(equal_cnt), 4);
    drive(0, 1, F_L); idle();
    chk("release lock", 32'(lock), 0);
    chk("release less_cnt", 32'(less_cnt), 1);
    chk("release last", 32'(last_result), 1);

    // Illegal code 110, then ignored samples, then clear
    drive(0, 1, 3'b110); idle();
    chk("illegal error", 32'(error), 1);
    chk("illegal less_cnt", 32'(less_cnt), 1);
    chk("illegal greater_cnt", 32'(greater_cnt), 0);
    chk("illegal equal_cnt", 32'(equal_cnt), 4);
    drive(0, 1, F_E); drive(0, 1, F_L); drive(0, 1, F_G); idle();
    chk("frozen equal_cnt", 32'(equal_cnt), 4);
    chk("frozen greater_cnt", 32'(greater_cnt), 0);
    chk("frozen last", 32'(last_result), 1);
    chk("frozen error", 32'(error), 1);
    drive(1, 0, 3'b000); idle();
    chk("clear error", 32'(error), 0);
    chk("clear equal_cnt", 32'(equal_cnt), 0);
    chk("clear last", 32'(last_result), 0);

    // Flags without sample_valid are don't-care; 000 with valid is illegal
    drive(0, 0, 3'b110); drive(0, 0, 3'b111); idle();
    chk("novalid error", 32'(error), 0);
    drive(0, 1, 3'b000); idle();
    chk("zero code error", 32'(error), 1);
    drive(1, 0, 3'b000);
    drive(0, 1, 3'b111); idle();
    chk("all-hot error", 32'(error), 1);
    drive(1, 0, 3'b000);

    // Saturation: small instance tops out at 3, wide one keeps counting
    for (int i = 0; i < 5; i++) drive(0, 1, F_L);
    idle();
    chk("sat s_less_cnt", 32'(s_less_cnt), 3);
    chk("sat s_greater_cnt", 32'(s_greater_cnt), 0);
    chk("sat s_equal_cnt", 32'(s_equal_cnt), 0);
    chk("sat less_cnt", 32'(less_cnt), 5);
    for (int i = 0; i < 260; i++) drive(0, 1, F_G);
    idle();
    chk("sat8 greater_cnt", 32'(greater_cnt), 255);
    chk("sat8 less_cnt", 32'(less_cnt), 5);
    chk("sat s_greater_cnt2", 32'(s_greater_cnt), 3);

    // Simultaneous clear and sample: clear wins and streak restarts
    drive(1, 0, 3'b000);
    drive(0, 1, F_E); idle();
    chk("pre-clear equal_cnt", 32'(equal_cnt), 1);
    drive(1, 1, F_E); idle();
    chk("clr+eq equal_cnt", 32'(equal_cnt), 0);
    chk("clr+eq last", 32'(last_result), 0);
    chk("clr+eq lock", 32'(lock), 0);
    drive(0, 1, F_E); drive(0, 1, F_E); idle();
    chk("streak restart lock", 32'(lock), 0);
    drive(0, 1, F_E); idle();
    chk("streak relock", 32'(lock), 1);

    // Asynchronous reset mid-cycle with nonzero counts
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async equal_cnt", 32'(equal_cnt), 0);
    chk("async less_cnt", 32'(less_cnt), 0);
    chk("async greater_cnt", 32'(greater_cnt), 0);
    chk("async last", 32'(last_result), 0);
    chk("async lock", 32'(lock), 0);
    chk("async error", 32'(error), 0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 1, F_G); idle();
    chk("post-reset greater_cnt", 32'(greater_cnt), 1);
    chk("post-reset last", 32'(last_result), 2);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
